spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter_pkg.sv | 36 +++
 rtl/rr_arbiter4.sv | 34 +++
 rtl/spi_txn_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_arbiter_pkg
// Description : Shared definitions for the SPI transaction arbiter: requester
//               count, timeout counter width, FSM state encoding and a
//               one-hot to index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_txn_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;
  localparam int TMO_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_READ    = 3'd5,
    ST_DONE    = 3'd6
  } txn_state_t;

  // Highest set bit wins; callers only ever pass a one-hot or zero vector.
  function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = REQ_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage : spi_txn_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Combinational 4-way round-robin selector. Searching starts at
//               (last_grant + 1) mod 4 and wraps so the previous winner has
//               the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import spi_txn_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [REQ_IDX_W-1:0] i_last_grant,
  output logic [NUM_REQ-1:0]   o_gnt
);

  // Walk the requesters in rotated order and take the first active one.
  always_comb begin
    logic                 w_found;
    logic [REQ_IDX_W-1:0] w_idx;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = i_last_grant + REQ_IDX_W'(k);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter4
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_arbiter
// Description : Arbitrates four requesters onto one SPI master. Each grant
//               runs one write/start/read transaction with a receive timeout
//               and reports a one-cycle done or error pulse to the winner.
//               All master-side controls and grant outputs come from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_done,
  output logic [NUM_REQ-1:0]             o_err,
  output logic [DATA_SIZE-1:0]           o_rdata,
  output logic                           o_busy,
  output logic                           o_spi_csn,
  output logic [DATA_SIZE-1:0]           o_spi_data,
  output logic                           o_spi_wr,
  output logic                           o_spi_rd,
  output logic                           o_spi_start,
  output logic [REQ_IDX_W-1:0]           o_slave_addr,
  input  logic [DATA_SIZE-1:0]           i_spi_data,
  input  logic                           i_tx_ready,
  input  logic                           i_rx_ready,
  input  logic                           i_tx_error,
  input  logic                           i_rx_error
);

  localparam logic [TMO_CNT_W-1:0] c_tmo_last = TMO_CNT_W'(TIMEOUT - 1);

  txn_state_t             r_state,      w_state_nxt;
  logic [REQ_IDX_W-1:0]   r_last_grant, w_last_nxt;
  logic [TMO_CNT_W-1:0]   r_tmo_cnt,    w_tmo_nxt;
  logic [NUM_REQ-1:0]     r_gnt,        w_gnt_nxt;
  logic [NUM_REQ-1:0]     r_done,       w_done_nxt;
  logic [NUM_REQ-1:0]     r_err,        w_err_nxt;
  logic                   r_spi_wr,     w_wr_nxt;
  logic                   r_spi_rd,     w_rd_nxt;
  logic                   r_spi_start,  w_start_nxt;
  logic                   r_spi_csn,    w_csn_nxt;
  logic [DATA_SIZE-1:0]   r_spi_data,   w_data_nxt;
  logic [DATA_SIZE-1:0]   r_rdata,      w_rdata_nxt;
  logic [REQ_IDX_W-1:0]   r_slave_addr, w_addr_nxt;

  logic [NUM_REQ-1:0]     w_rr_gnt;
  logic [REQ_IDX_W-1:0]   w_rr_idx;
  logic [DATA_SIZE-1:0]   w_wdata_sel;
  logic                   w_abort;
  logic                   w_xfer_err;

  rr_arbiter4 u_rr (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_rr_gnt)
  );

  assign w_rr_idx    = onehot_to_idx(w_rr_gnt);
  assign w_wdata_sel = i_req_wdata[int'(w_rr_idx)*DATA_SIZE +: DATA_SIZE];
  assign w_xfer_err  = i_tx_error | i_rx_error;

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_tmo_nxt   = r_tmo_cnt;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_start_nxt = 1'b0;
    w_csn_nxt   = r_spi_csn;
    w_data_nxt  = r_spi_data;
    w_rdata_nxt = r_rdata;
    w_addr_nxt  = r_slave_addr;
    w_abort     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_csn_nxt = 1'b1;
        if (|i_req) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        // A requester that dropped before arbitration simply yields no grant.
        if (|w_rr_gnt) begin
          w_gnt_nxt   = w_rr_gnt;
          w_addr_nxt  = w_rr_idx;
          w_data_nxt  = w_wdata_sel;
          w_csn_nxt   = 1'b0;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_xfer_err) begin
          w_abort = 1'b1;
        end else if (i_tx_ready) begin
          w_wr_nxt    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_xfer_err) begin
          w_abort = 1'b1;
        end else begin
          w_start_nxt = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        // rx_ready is tested before the timeout so it wins a tie.
        if (w_xfer_err) begin
          w_abort = 1'b1;
        end else if (i_rx_ready) begin
          w_state_nxt = ST_READ;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_abort = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      ST_READ: begin
        w_rd_nxt    = 1'b1;
        w_rdata_nxt = i_spi_data;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done_nxt  = r_gnt;
        w_last_nxt  = r_slave_addr;
        w_gnt_nxt   = '0;
        w_csn_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      w_err_nxt   = r_gnt;
      w_last_nxt  = r_slave_addr;
      w_gnt_nxt   = '0;
      w_csn_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  // State and output registers; reset forces the bus idle immediately.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ_IDX_W'(NUM_REQ - 1);
      r_tmo_cnt    <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_spi_wr     <= 1'b0;
      r_spi_rd     <= 1'b0;
      r_spi_start  <= 1'b0;
      r_spi_csn    <= 1'b1;
      r_spi_data   <= '0;
      r_rdata      <= '0;
      r_slave_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_spi_wr     <= w_wr_nxt;
      r_spi_rd     <= w_rd_nxt;
      r_spi_start  <= w_start_nxt;
      r_spi_csn    <= w_csn_nxt;
      r_spi_data   <= w_data_nxt;
      r_rdata      <= w_rdata_nxt;
      r_slave_addr <= w_addr_nxt;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_rdata      = r_rdata;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_spi_csn    = r_spi_csn;
  assign o_spi_data   = r_spi_data;
  assign o_spi_wr     = r_spi_wr;
  assign o_spi_rd     = r_spi_rd;
  assign o_spi_start  = r_spi_start;
  assign o_slave_addr = r_slave_addr;

endmodule : spi_txn_arbiter
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_txn_arbiter
// Description : Directed self-checking bench for spi_txn_arbiter with a
//               scoreboard of expected grants and completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_arbiter;

  localparam int DW = 16;

  logic           i_sys_clk = 1'b0;
  logic           i_sys_rst = 1'b1;
  logic [3:0]     i_req = '0;
  logic [4*DW-1:0] i_req_wdata;
  logic [3:0]     o_gnt, o_done, o_err;
  logic [DW-1:0]  o_rdata, o_spi_data, i_spi_data;
  logic           o_busy, o_spi_csn, o_spi_wr, o_spi_rd, o_spi_start;
  logic [1:0]     o_slave_addr;
  logic           i_tx_ready = 1'b1, i_rx_ready = 1'b1;
  logic           i_tx_error = 1'b0, i_rx_error = 1'b0;

  logic [DW-1:0]  wdata [4];
  logic [DW-1:0]  slave_rdata [4];

  typedef struct {
    int           idx;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit           is_err;
    bit           tmo;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_fail = 0;
  int n_wr = 0, n_rd = 0, n_start = 0;
  int cyc = 0, start_cyc = 0;
  logic [3:0] prev_gnt = '0;

  assign i_req_wdata = {wdata[3], wdata[2], wdata[1], wdata[0]};
  assign i_spi_data  = slave_rdata[o_slave_addr];

  always #5 i_sys_clk = ~i_sys_clk;

  spi_txn_arbiter #(.DATA_SIZE(DW), .TIMEOUT(16)) dut (
    .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_req(i_req), .i_req_wdata(i_req_wdata),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_spi_csn(o_spi_csn), .o_spi_data(o_spi_data), .o_spi_wr(o_spi_wr), .o_spi_rd(o_spi_rd),
    .o_spi_start(o_spi_start), .o_slave_addr(o_slave_addr), .i_spi_data(i_spi_data),
    .i_tx_ready(i_tx_ready), .i_rx_ready(i_rx_ready), .i_tx_error(i_tx_error),
    .i_rx_error(i_rx_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(4'b0001 << i);
  endfunction

  task automatic push_exp(input int idx, input logic [DW-1:0] rdata, input bit is_err, input bit tmo);
    exp_t e;
    e.idx = idx; e.wdata = wdata[idx]; e.rdata = rdata; e.is_err = is_err; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  32'(o_gnt), 32'h0);
    check({tag, "_resp"}, 32'({o_done, o_err}), 32'h0);
    check({tag, "_strb"}, 32'({o_spi_wr, o_spi_rd, o_spi_start}), 32'h0);
    check({tag, "_csn"},  32'(o_spi_csn), 32'h1);
    check({tag, "_data"}, 32'({o_spi_data, o_rdata}), 32'h0);
    check({tag, "_addr_busy"}, 32'({o_slave_addr, o_busy}), 32'h0);
  endtask

  // Hold each requester in mask until it sees its done/err pulse.
  task automatic serve(input logic [3:0] mask, input int budget);
    logic [3:0] pend;
    int k;
    pend = mask; k = 0;
    i_req = pend;
    while (pend != 4'b0 && k < budget) begin
      @(posedge i_sys_clk); #1;
      k++;
      pend = pend & ~(o_done | o_err);
      i_req = pend;
    end
    i_req = '0;
    check("serve_complete", 32'(pend), 32'h0);
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    do begin
      @(posedge i_sys_clk); #1;
      k++;
    end while (!o_spi_start && k < budget);
    check("start_seen", 32'(o_spi_start), 32'h1);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge i_sys_clk) begin
    exp_t e;
    cyc++;
    if (o_spi_start) begin n_start++; start_cyc = cyc; end
    if (o_spi_rd) n_rd++;
    if (o_spi_wr) begin
      n_wr++;
      if (exp_q.size() != 0) check("wr_data", 32'(o_spi_data), 32'(exp_q[0].wdata));
    end
    if (o_gnt != 4'b0 && prev_gnt == 4'b0) begin
      if (exp_q.size() != 0) begin
        check("gnt", 32'(o_gnt), 32'(oh(exp_q[0].idx)));
        check("slave_addr", 32'(o_slave_addr), 32'(exp_q[0].idx));
      end else begin
        check("unexpected_gnt", 32'(o_gnt), 32'h0);
      end
    end
    if (o_done != 4'b0 || o_err != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'({o_done, o_err}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("done", 32'(o_done), e.is_err ? 32'h0 : 32'(oh(e.idx)));
        check("err",  32'(o_err),  e.is_err ? 32'(oh(e.idx)) : 32'h0);
        check("rdata", 32'(o_rdata), 32'(e.rdata));
        if (e.tmo) check("tmo_cycles", 32'(cyc - start_cyc), 32'd16);
      end
    end
    prev_gnt = o_gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, k, wr0, rd0, st0;
    for (int n = 0; n < 4; n++) begin
      wdata[n]       = 16'(16'hC000 + 16'(n) * 16'h0111);
      slave_rdata[n] = 16'(16'h5A00 + 16'(n));
    end

    // Reset values while reset is held
    repeat (3) @(posedge i_sys_clk);
    #1 check_reset_outputs("reset");
    i_sys_rst = 1'b0;
    @(posedge i_sys_clk); #1;

    // Round robin from reset: 0,1,2,3,0
    for (int n = 0; n < 4; n++) push_exp(n, slave_rdata[n], 1'b0, 1'b0);
    push_exp(0, slave_rdata[0], 1'b0, 1'b0);
    i_req = 4'b1111; cnt = 0; k = 0;
    while (cnt < 5 && k < 300) begin
      @(posedge i_sys_clk); #1;
      k++;
      if (o_done != 4'b0) cnt++;
    end
    i_req = '0;
    check("rr_done_count", 32'(cnt), 32'd5);

    // Single request on requester 0
    wdata[0] = 16'hA5C3; slave_rdata[0] = 16'h1234;
    wr0 = n_wr; st0 = n_start;
    push_exp(0, 16'h1234, 1'b0, 1'b0);
    serve(4'b0001, 100);
    check("single_wr_count", 32'(n_wr - wr0), 32'd1);
    check("single_start_count", 32'(n_start - st0), 32'd1);
    check("single_rdata", 32'(o_rdata), 32'h1234);

    // Receive timeout on requester 1, rdata must be preserved
    i_rx_ready = 1'b0;
    push_exp(1, 16'h1234, 1'b1, 1'b1);
    serve(4'b0010, 100);
    i_rx_ready = 1'b1;
    push_exp(3, slave_rdata[3], 1'b0, 1'b0);
    serve(4'b1000, 100);

    // Receive error while waiting on requester 2
    i_rx_ready = 1'b0;
    rd0 = n_rd;
    push_exp(2, slave_rdata[3], 1'b1, 1'b0);
    i_req = 4'b0100;
    wait_start(50);
    i_rx_error = 1'b1;
    serve(4'b0100, 50);
    i_rx_error = 1'b0;
    i_rx_ready = 1'b1;
    check("rxerr_csn", 32'(o_spi_csn), 32'h1);
    check("rxerr_no_rd", 32'(n_rd - rd0), 32'd0);

    // tx_ready held low in LOAD delays the write strobe
    i_tx_ready = 1'b0;
    wr0 = n_wr;
    push_exp(0, slave_rdata[0], 1'b0, 1'b0);
    i_req = 4'b0001;
    k = 0;
    do begin @(posedge i_sys_clk); #1; k++; end while (o_gnt == 4'b0 && k < 20);
    repeat (10) @(posedge i_sys_clk);
    #1 check("txwait_no_wr", 32'(n_wr - wr0), 32'd0);
    i_tx_ready = 1'b1;
    serve(4'b0001, 50);
    check("txwait_one_wr", 32'(n_wr - wr0), 32'd1);

    // Reset in WAIT_RX, then first grant must go to requester 0
    i_rx_ready = 1'b0;
    push_exp(1, 16'h0, 1'b0, 1'b0);
    i_req = 4'b0010;
    wait_start(50);
    repeat (3) @(posedge i_sys_clk);
    #2 i_sys_rst = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    i_req = '0;
    repeat (2) @(posedge i_sys_clk);
    #3 i_sys_rst = 1'b0;
    i_rx_ready = 1'b1;
    push_exp(0, slave_rdata[0], 1'b0, 1'b0);
    push_exp(1, slave_rdata[1], 1'b0, 1'b0);
    serve(4'b0011, 100);
    repeat (3) @(posedge i_sys_clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_spi_txn_arbiter
`default_nettype wire
